// File: rtl/f32_pkg.sv
// f32_pkg: shared binary32 types, FSM states and constants
// for the f32_acc accumulator.
package f32_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } f32_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND
    } state_e;

    localparam int          F32_BIAS    = 127;
    localparam logic [7:0]  F32_EMAX    = 8'(2 * F32_BIAS + 1);
    localparam logic [31:0] F32_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] F32_POS_INF = 32'h7F80_0000;

endpackage

// File: rtl/f32_lzc.sv
// f32_lzc: 28-bit leading-zero counter; returns 28 for
// an all-zero input.
module f32_lzc (
    input  logic [27:0] data_i,
    output logic [4:0]  lzc_o
);

    // scan upward so the highest set bit wins
    always_comb begin
        lzc_o = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (data_i[i]) lzc_o = 5'(27 - i);
        end
    end

endmodule

// File: rtl/f32_acc.sv
// f32_acc: six-cycle binary32 accumulator, RNE rounding,
// sticky flags. F32_ACC_COUNT_EN adds a result counter.
module f32_acc
    import f32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_underflow,
    input  logic        in_overflow,
    output logic        in_ready,
    output logic        done,
    output logic [31:0] sum_o,
    output logic        underflow_o,
    output logic        overflow_o,
    output logic        lost_o
`ifdef F32_ACC_COUNT_EN
    ,
    output logic [15:0] count_o
`endif
);

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   accept;

    f32_t        b_q;
    logic [31:0] sum_q;
    logic        of_q, uf_q, lost_q;

    logic        as_q, bs_q;
    logic [7:0]  ae_q, be_q;
    logic [23:0] am_q, bm_q;
    logic        spec_q;
    logic [31:0] specv_q;

    logic        sign_q, sub_q;
    logic [7:0]  exp_q;
    logic [26:0] big_q, sml_q;
    logic [27:0] add_q;

    logic signed [9:0] nexp_q;
    logic [26:0]       nman_q;
    logic              nzero_q;

    f32_t        ua, ub;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        a_big;
    logic [7:0]  diff;
    logic [53:0] ext;
    logic [26:0] sml_d;
    logic [4:0]  lzc;
    logic [27:0] norm;
    logic        rup;
    logic [24:0] m25;
    logic signed [9:0] e_r;
    logic [31:0] res;
    logic        r_of, r_uf;

    assign accept   = (state_q == S_IDLE) && in_valid;
    assign sum_o    = sum_q;
    assign done     = done_q;
    assign overflow_o  = of_q;
    assign underflow_o = uf_q;
    assign lost_o   = lost_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: fixed walk, clear aborts
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (in_valid) state_d = S_UNPACK;
            S_UNPACK: state_d = S_ALIGN;
            S_ALIGN:  state_d = S_ADD;
            S_ADD:    state_d = S_NORM;
            S_NORM:   state_d = S_ROUND;
            S_ROUND:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (clear && state_q != S_IDLE) state_d = S_IDLE;
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == S_IDLE);
        done_d   = (state_q == S_ROUND) && !clear;
    end

    // done pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= done_d;
    end

    // unpack: flush subnormals, hidden bit, specials
    always_comb begin
        ua    = f32_t'(sum_q);
        ub    = b_q;
        a_nan = (ua.exp == F32_EMAX) && (ua.man != '0);
        b_nan = (ub.exp == F32_EMAX) && (ub.man != '0);
        a_inf = (ua.exp == F32_EMAX) && (ua.man == '0);
        b_inf = (ub.exp == F32_EMAX) && (ub.man == '0);
    end

    // align: order by magnitude, shift with sticky
    always_comb begin
        a_big = {ae_q, am_q} >= {be_q, bm_q};
        diff  = a_big ? ae_q - be_q : be_q - ae_q;
        ext   = {(a_big ? bm_q : am_q), 30'b0} >> diff;
        if (diff >= 8'd27) begin
            sml_d = {26'b0, (a_big ? bm_q : am_q) != '0};
        end else begin
            sml_d = ext[53:27];
            sml_d[0] = ext[27] | (ext[26:0] != '0);
        end
    end

    f32_lzc u_lzc (
        .data_i (add_q),
        .lzc_o  (lzc)
    );

    assign norm = add_q << lzc;

    // round to nearest even and range check
    always_comb begin
        rup  = nman_q[2] & (nman_q[1] | nman_q[0] | nman_q[3]);
        m25  = {1'b0, nman_q[26:3]} + 25'(rup);
        e_r  = nexp_q + (m25[24] ? 10'sd1 : 10'sd0);
        r_of = 1'b0;
        r_uf = 1'b0;
        if (spec_q) begin
            res = specv_q;
        end else if (nzero_q) begin
            res = 32'h0;
        end else if (e_r >= 10'sd255) begin
            res  = F32_POS_INF | {sign_q, 31'b0};
            r_of = 1'b1;
        end else if (e_r <= 10'sd0) begin
            res  = {sign_q, 31'b0};
            r_uf = 1'b1;
        end else begin
            res = {sign_q, e_r[7:0],
                   m25[24] ? m25[23:1] : m25[22:0]};
        end
    end

    // datapath stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q     <= '0;
            as_q    <= 1'b0;
            bs_q    <= 1'b0;
            ae_q    <= '0;
            be_q    <= '0;
            am_q    <= '0;
            bm_q    <= '0;
            spec_q  <= 1'b0;
            specv_q <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= '0;
            big_q   <= '0;
            sml_q   <= '0;
            add_q   <= '0;
            nexp_q  <= '0;
            nman_q  <= '0;
            nzero_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (in_valid) b_q <= f32_t'(in_data);
                S_UNPACK: begin
                    as_q <= ua.sign;
                    bs_q <= ub.sign;
                    ae_q <= ua.exp;
                    be_q <= ub.exp;
                    am_q <= (ua.exp == '0) ? '0 : {1'b1, ua.man};
                    bm_q <= (ub.exp == '0) ? '0 : {1'b1, ub.man};
                    spec_q  <= 1'b1;
                    if (a_nan || b_nan ||
                        (a_inf && b_inf && ua.sign != ub.sign))
                        specv_q <= F32_QNAN;
                    else if (a_inf)
                        specv_q <= {ua.sign, F32_POS_INF[30:0]};
                    else if (b_inf)
                        specv_q <= {ub.sign, F32_POS_INF[30:0]};
                    else if (ua.exp == '0 && ub.exp == '0)
                        specv_q <= {ua.sign & ub.sign, 31'b0};
                    else
                        spec_q <= 1'b0;
                end
                S_ALIGN: begin
                    sign_q <= a_big ? as_q : bs_q;
                    exp_q  <= a_big ? ae_q : be_q;
                    big_q  <= {(a_big ? am_q : bm_q), 3'b0};
                    sml_q  <= sml_d;
                    sub_q  <= as_q ^ bs_q;
                end
                S_ADD: begin
                    add_q <= sub_q ? {1'b0, big_q} - {1'b0, sml_q}
                                   : {1'b0, big_q} + {1'b0, sml_q};
                end
                S_NORM: begin
                    nzero_q <= (add_q == '0);
                    nexp_q  <= $signed({2'b0, exp_q}) + 10'sd1
                             - $signed({5'b0, lzc});
                    nman_q  <= {norm[27:2], norm[1] | norm[0]};
                end
                default: ;
            endcase
        end
    end

    // running sum and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            of_q   <= 1'b0;
            uf_q   <= 1'b0;
            lost_q <= 1'b0;
        end else if (clear) begin
            sum_q  <= '0;
            of_q   <= accept & in_overflow;
            uf_q   <= accept & in_underflow;
            lost_q <= 1'b0;
        end else begin
            if (accept) begin
                of_q <= of_q | in_overflow;
                uf_q <= uf_q | in_underflow;
            end
            if (in_valid && state_q != S_IDLE) lost_q <= 1'b1;
            if (state_q == S_ROUND) begin
                sum_q <= res;
                of_q  <= of_q | r_of;
                uf_q  <= uf_q | r_uf;
            end
        end
    end

`ifdef F32_ACC_COUNT_EN
    logic [15:0] cnt_q;

    // result counter, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= accept ? 16'd1 : 16'd0;
        else if (done_d && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign count_o = cnt_q;
`endif

endmodule

// File: tb/tb_f32_acc.sv
// tb_f32_acc: directed checks of the f32_acc accumulator.
module tb_f32_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_underflow;
    logic        in_overflow;
    logic        in_ready;
    logic        done;
    logic [31:0] sum_o;
    logic        underflow_o;
    logic        overflow_o;
    logic        lost_o;

    int n_tests = 0;
    int n_fail  = 0;

    f32_acc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_underflow (in_underflow),
        .in_overflow  (in_overflow),
        .in_ready     (in_ready),
        .done         (done),
        .sum_o        (sum_o),
        .underflow_o  (underflow_o),
        .overflow_o   (overflow_o),
        .lost_o       (lost_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // accept one addend, return cycles from accept to done
    task automatic add(input logic [31:0] v,
                       input logic ov,
                       output int lat);
        in_valid    = 1'b1;
        in_data     = v;
        in_overflow = ov;
        step();
        in_valid    = 1'b0;
        in_overflow = 1'b0;
        lat = 0;
        while (!done && lat < 12) begin
            step();
            lat++;
        end
    endtask

    int  lat;
    int  seen;

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_underflow = 1'b0;
        in_overflow = 1'b0;
        step();
        step();
        chk("rst_sum", sum_o, 32'h0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", {29'b0, overflow_o, underflow_o, lost_o}, 32'h0);
        rst_n = 1'b1;
        step();

        add(32'h3F80_0000, 1'b0, lat);
        chk("lat1", 32'(lat), 32'd5);
        add(32'h4000_0000, 1'b0, lat);
        chk("lat2", 32'(lat), 32'd5);
        chk("ready_done", 32'(in_ready), 32'd1);
        chk("sum_3", sum_o, 32'h4040_0000);
        step();
        chk("done_fall", 32'(done), 32'd0);

        do_clear();
        chk("clr_sum", sum_o, 32'h0);
        add(32'h3F80_0000, 1'b0, lat);
        add(32'h3F80_0000, 1'b0, lat);
        chk("sum_2", sum_o, 32'h4000_0000);
        add(32'hC000_0000, 1'b0, lat);
        chk("cancel", sum_o, 32'h0);
        chk("cancel_flags", {30'b0, overflow_o, underflow_o}, 32'h0);

        do_clear();
        add(32'h3F80_0000, 1'b0, lat);
        add(32'h3380_0000, 1'b0, lat);
        chk("rne_tie", sum_o, 32'h3F80_0000);
        do_clear();
        add(32'h3F80_0000, 1'b0, lat);
        add(32'h3380_0001, 1'b0, lat);
        chk("rne_up", sum_o, 32'h3F80_0001);

        do_clear();
        add(32'h7F7F_FFFF, 1'b0, lat);
        add(32'h7F7F_FFFF, 1'b0, lat);
        chk("ovf_sum", sum_o, 32'h7F80_0000);
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        do_clear();
        chk("ovf_clr", 32'(overflow_o), 32'd0);

        add(32'h7F80_0000, 1'b0, lat);
        chk("inf_sum", sum_o, 32'h7F80_0000);
        add(32'hFF80_0000, 1'b0, lat);
        chk("inf_nan", sum_o, 32'h7FC0_0000);
        do_clear();
        add(32'h3F80_0000, 1'b1, lat);
        chk("in_ovf", 32'(overflow_o), 32'd1);
        chk("in_ovf_sum", sum_o, 32'h3F80_0000);

        do_clear();
        add(32'h0080_0001, 1'b0, lat);
        add(32'h8080_0000, 1'b0, lat);
        chk("unf_sum", sum_o, 32'h0);
        chk("unf_flag", 32'(underflow_o), 32'd1);
        do_clear();
        add(32'h0000_0001, 1'b0, lat);
        chk("subn_flush", sum_o, 32'h0);

        do_clear();
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        step();
        in_valid = 1'b0;
        step();
        chk("busy_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        step();
        in_valid = 1'b0;
        chk("lost_set", 32'(lost_o), 32'd1);
        lat = 0;
        while (!done && lat < 12) begin
            step();
            lat++;
        end
        chk("lost_done", 32'(done), 32'd1);
        chk("lost_sum", sum_o, 32'h3F80_0000);

        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        step();
        in_valid = 1'b0;
        step();
        step();
        do_clear();
        chk("abort_sum", sum_o, 32'h0);
        chk("abort_lost", 32'(lost_o), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            step();
        end
        chk("abort_nodone", 32'(seen), 32'd0);
        chk("abort_sum2", sum_o, 32'h0);

        add(32'h3F80_0000, 1'b0, lat);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h4000_0000;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        lat = 0;
        while (!done && lat < 12) begin
            step();
            lat++;
        end
        chk("clr_acc_lat", 32'(lat), 32'd5);
        chk("clr_acc_sum", sum_o, 32'h4000_0000);

        add(32'h3F80_0000, 1'b0, lat);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_sum", sum_o, 32'h0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            step();
        end
        chk("arst_nodone", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
